// File: rtl/ntt_butterfly_stage.sv
// rtl/ntt_butterfly_stage.sv - radix-2 NTT butterfly stage, 128 lanes per beat, Barrett reduction, latency 5
module ntt_butterfly_stage #(
  parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
  parameter int unsigned INPUT_PER_CYCLE      = 128,
  parameter int unsigned N                    = 1024,
  parameter int unsigned Q                    = 132120577,
  parameter logic [2*DATA_WIDTH_PER_INPUT:0] BARRETT_MU =
    (2*DATA_WIDTH_PER_INPUT+1)'((64'd1 << (2*DATA_WIDTH_PER_INPUT)) / 64'(Q)),
  // Twiddle ROM image (converted from the stage's twiddle hex): one word per beat,
  // beat b at [b*ROWW +: ROWW], butterfly k of that word at [k*W +: W]. Default: all w=1.
  parameter logic [(N/INPUT_PER_CYCLE)*(INPUT_PER_CYCLE/2)*DATA_WIDTH_PER_INPUT-1:0] TWIDDLE_ROM =
    {((N/INPUT_PER_CYCLE)*(INPUT_PER_CYCLE/2)){{(DATA_WIDTH_PER_INPUT-1){1'b0}}, 1'b1}}
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] inData,
  input  logic                                            in_start,
  output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] outData,
  output logic                                            out_start
);

  localparam int unsigned W     = DATA_WIDTH_PER_INPUT;
  localparam int unsigned HALF  = INPUT_PER_CYCLE / 2;
  localparam int unsigned BEATS = N / INPUT_PER_CYCLE;
  localparam int unsigned ROWW  = HALF * W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAT   = 5;
  localparam int unsigned PW    = 4 * W + 1;

  localparam logic [W+1:0]   QX = (W+2)'(Q);
  localparam logic [2*W-1:0] Q2 = (2*W)'(Q);
  localparam logic [W:0]     Q1 = (W+1)'(Q);

  typedef enum logic {IDLE, RUN} stateT;

  stateT          state, stateNext;
  logic [CW-1:0]  beatCnt, beatCntNext, beatIdx;
  logic [ROWW-1:0] romWord;
  logic [LAT-1:0] startPipe;

  // Beat index of the data on inData this cycle; a start always presents beat 0.
  always_comb begin
    beatIdx = '0;
    if (!in_start && state == RUN) beatIdx = beatCnt;
  end

  // Next-state logic: a start (even on the last beat) restarts the frame; otherwise run to BEATS-1.
  always_comb begin
    stateNext   = IDLE;
    beatCntNext = '0;
    if (in_start || (state == RUN && beatCnt != CW'(BEATS - 1))) begin
      stateNext   = RUN;
      beatCntNext = beatIdx + 1'b1;
    end
  end

  // FSM state and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      state   <= stateNext;
      beatCnt <= beatCntNext;
    end
  end

  // Twiddle word for the current beat; registered per butterfly alongside a and b.
  always_comb begin
    romWord = TWIDDLE_ROM[int'(beatIdx)*ROWW +: ROWW];
  end

  // Frame start marker travels alongside the data through the five pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) startPipe <= '0;
    else     startPipe <= {startPipe[LAT-2:0], in_start};
  end

  assign out_start = startPipe[LAT-1];

  for (genvar k = 0; k < HALF; k++) begin : gBfly
    logic [W-1:0]   a1, b1, w1, a2, a3, a4, t3, r4, sum5, diff5;
    logic [2*W-1:0] p2, p3;
    logic [W+1:0]   r0, r1, r2;
    logic [W:0]     sumRaw, diffRaw;

    // Barrett remainder p - t*Q lies in [0, 3Q), so two conditional subtractions finish it.
    always_comb begin
      r0 = (W+2)'(p3 - (2*W)'(t3) * Q2);
      r1 = (r0 >= QX) ? r0 - QX : r0;
      r2 = (r1 >= QX) ? r1 - QX : r1;
    end

    // Final add/subtract at W+1 bits; the top bit of diffRaw is the borrow.
    always_comb begin
      sumRaw  = {1'b0, a4} + {1'b0, r4};
      diffRaw = {1'b0, a4} - {1'b0, r4};
    end

    // Five-stage butterfly: capture, multiply, Barrett quotient, reduce, add/sub.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a1 <= '0; b1 <= '0; w1 <= '0;
        a2 <= '0; p2 <= '0;
        a3 <= '0; p3 <= '0; t3 <= '0;
        a4 <= '0; r4 <= '0;
        sum5 <= '0; diff5 <= '0;
      end else begin
        a1    <= inData[(2*k)*W +: W];
        b1    <= inData[(2*k+1)*W +: W];
        w1    <= romWord[k*W +: W];
        a2    <= a1;
        p2    <= (2*W)'(w1) * (2*W)'(b1);
        a3    <= a2;
        p3    <= p2;
        t3    <= W'((PW'(p2) * PW'(BARRETT_MU)) >> (2*W));
        a4    <= a3;
        r4    <= W'(r2);
        sum5  <= (sumRaw >= Q1) ? W'(sumRaw - Q1) : W'(sumRaw);
        diff5 <= diffRaw[W] ? W'(diffRaw + Q1) : W'(diffRaw);
      end
    end

    assign outData[(2*k)*W +: W]   = sum5;
    assign outData[(2*k+1)*W +: W] = diff5;
  end

endmodule

// File: doc/ntt_butterfly_stage.md
Name: ntt_butterfly_stage

Overview:
- Radix-2 NTT butterfly stage for the N=1024, 128-lanes-per-cycle datapath.
- Sits directly downstream of a stage_k_permutation block and consumes its outData lanes and out_start pulse.
- Lanes 2k and 2k+1 form one butterfly pair. Each pair computes a+w·b mod Q and a−w·b mod Q, with twiddle w taken from a per-stage ROM.
- Output feeds the next stage's permutation. Fully pipelined, one 128-lane beat per cycle.

Parameters:
- DATA_WIDTH_PER_INPUT, 28, bits per coefficient.
- INPUT_PER_CYCLE, 128, lanes per beat; must be even. Butterflies per beat = INPUT_PER_CYCLE/2.
- N, 1024, coefficients per frame. Beats per frame BEATS = N/INPUT_PER_CYCLE = 8.
- Q, 132120577, modulus; must be < 2^DATA_WIDTH_PER_INPUT.
- BARRETT_MU, floor(2^56/Q), Barrett constant; 2·DATA_WIDTH_PER_INPUT+1 bits wide.
- TWIDDLE_FILE, "twiddle_stage.hex", $readmemh image. BEATS words of (INPUT_PER_CYCLE/2)·DATA_WIDTH_PER_INPUT bits; butterfly k occupies bits [k·W +: W].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- inData  in  INPUT_PER_CYCLE·DATA_WIDTH_PER_INPUT  flattened lanes; lane i at [i·W +: W]; values < Q.
- in_start  in  1  one-cycle pulse coincident with beat 0 of a frame; beats 1..7 follow on consecutive cycles.
- outData  out  INPUT_PER_CYCLE·DATA_WIDTH_PER_INPUT  flattened results; lane 2k = a+wb, lane 2k+1 = a−wb, both mod Q.
- out_start  out  1  one-cycle pulse coincident with output beat 0.

Behaviour:
- Reset (asynchronous, active-high): outData=0, out_start=0, beat counter=0, FSM=IDLE, all pipeline registers and valid/start shift bits cleared. Applies immediately, including mid-frame; any frame in flight is discarded and produces no out_start.
- FSM states:
  - IDLE: in_start → RUN with beat counter=0.
  - RUN: counter increments each cycle. At counter=BEATS−1 with no in_start → IDLE.
  - in_start while in RUN (including on the last beat) restarts the counter at 0. The new frame wins; the earlier frame's already-issued beats still drain.
- Twiddle ROM: address = current beat index (0 while IDLE; 0 on the in_start cycle). Read is registered, aligned with the stage-1 input registers.
- Pipeline, latency L=5 cycles from the input beat to the matching outData:
  - S1: register a, b, w.
  - S2: p = w·b, 56-bit.
  - S3: t = (p · BARRETT_MU) >> 56.
  - S4: r = p − t·Q; subtract Q up to twice so that r < Q.
  - S5: sum = a+r, subtract Q if ≥ Q; diff = a−r, add Q if negative. Both registered into outData.
- out_start = in_start delayed exactly 5 cycles, via a shift register.
- outData updates every cycle; it is meaningful only on the BEATS cycles starting at out_start.
- Arithmetic widths: a+r is computed at W+1 bits; a−r uses a W+1-bit signed borrow. Results are always in [0, Q−1].
- Inputs ≥ Q are unsupported; output is undefined but must not hang the FSM.

Test Plan:
- Reset check: hold rst high 2 cycles, then release and apply no in_start → outData=0 and out_start=0 indefinitely.
- Identity twiddles (all w=1), lane pairs a=5, b=3 on beat 0, in_start pulse → exactly 5 cycles later out_start=1, lane0=8, lane1=2.
- Wrap in both directions, w=1:
  - a=2, b=5 → lane0=7, lane1=132120574 (Q−3).
  - a=Q−1, b=Q−1 → lane0=Q−2, lane1=0.
- Modular multiply with w=2 in beat-3 ROM word: b=Q−1, a=0 on beat 3 → beat 3 of output gives lane0=Q−2, lane1=2.
- Back-to-back frames:
  - Frame 1 uses inData lanes i = offset+i, offset += 128 per beat, for 8 beats.
  - A second in_start arrives on the cycle after beat 7.
  - Required: two out_start pulses 8 cycles apart, and per-beat twiddle selection matches the ROM word for the beat index in each frame.
- Reset mid-frame: assert rst at beat 4 for 1 cycle → outData=0 immediately and no out_start for the aborted frame. A new in_start 3 cycles later yields a correct frame with latency 5.
